// File: rtl/cluster_pkg.sv
// Shared defaults, invalid-address constant and FSM encoding for the cluster extractor.
package cluster_pkg;

    localparam int unsigned DEF_MXPADS     = 768;
    localparam int unsigned DEF_MXCNTBITS  = 3;
    localparam int unsigned DEF_MXADRBITS  = 11;
    localparam int unsigned DEF_MXCLUSTERS = 8;
    localparam int unsigned DEF_MXIDXBITS  = 4;

    localparam logic [DEF_MXADRBITS-1:0] ADR_INVALID = '1;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain
    } state_e;

endpackage

// File: rtl/first_set_encoder.sv
// Combinational lowest-set-bit finder built as a binary tree; the left subtree wins ties,
// so the lowest pad index always wins.
module first_set_encoder #(
    parameter int unsigned MXPADS    = 768,
    parameter int unsigned MXADRBITS = 11
) (
    input  logic [MXPADS-1:0]    vpf_i,
    output logic                 found_o,
    output logic [MXADRBITS-1:0] adr_o
);

    localparam int unsigned LEVELS = (MXPADS > 1) ? $clog2(MXPADS) : 1;
    localparam int unsigned LEAVES = 1 << LEVELS;

    // Node layout: {found, index}
    typedef logic [MXADRBITS:0] node_t;

    // Heap-ordered tree: node k has children 2k+1 and 2k+2; leaves are zero-padded past MXPADS.
    function automatic node_t search(input logic [LEAVES-1:0] leaves);
        node_t tree [2*LEAVES-1];
        for (int i = 0; i < int'(LEAVES); i++) begin
            tree[int'(LEAVES)-1+i] = {leaves[i], MXADRBITS'(i)};
        end
        for (int k = int'(LEAVES) - 2; k >= 0; k--) begin
            tree[k] = tree[2*k+1][MXADRBITS] ? tree[2*k+1] : tree[2*k+2];
        end
        return tree[0];
    endfunction

    logic [LEAVES-1:0] leaves;
    node_t             root;

    assign leaves  = LEAVES'(vpf_i);
    assign root    = search(leaves);
    assign found_o = root[MXADRBITS];
    assign adr_o   = root[MXADRBITS-1:0];

endmodule

// File: rtl/cluster_extractor.sv
// Serially extracts up to MXCLUSTERS clusters per frame in ascending pad order, masking each
// found pad before the next search; one registered beat per output handshake.
module cluster_extractor
    import cluster_pkg::*;
#(
    parameter int unsigned MXPADS     = DEF_MXPADS,
    parameter int unsigned MXCNTBITS  = DEF_MXCNTBITS,
    parameter int unsigned MXADRBITS  = DEF_MXADRBITS,
    parameter int unsigned MXCLUSTERS = DEF_MXCLUSTERS,
    parameter int unsigned MXIDXBITS  = DEF_MXIDXBITS
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MXPADS-1:0]             vpfs_in,
    input  logic [MXPADS*MXCNTBITS-1:0]   cnts_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_found,
    output logic [MXADRBITS-1:0]          adr,
    output logic [MXCNTBITS-1:0]          cnt,
    output logic [MXIDXBITS-1:0]          idx,
    output logic                          out_last,
    output logic                          overflow
);

    localparam logic [MXADRBITS-1:0] ADR_NONE = '1;
    localparam logic [MXIDXBITS-1:0] IDX_LAST = MXIDXBITS'(MXCLUSTERS - 1);

    state_e                        state_q, state_d;
    logic [MXPADS-1:0]             work_vpf_q, work_vpf_d;
    logic [MXPADS*MXCNTBITS-1:0]   work_cnt_q, work_cnt_d;
    logic [MXIDXBITS-1:0]          ctr_q, ctr_d;
    logic                          out_valid_q, out_valid_d;
    logic                          out_found_q, out_found_d;
    logic [MXADRBITS-1:0]          adr_q, adr_d;
    logic [MXCNTBITS-1:0]          cnt_q, cnt_d;
    logic [MXIDXBITS-1:0]          idx_q, idx_d;
    logic                          out_last_q, out_last_d;
    logic                          overflow_q, overflow_d;

    logic                 hit;
    logic [MXADRBITS-1:0] hit_adr;
    logic [MXPADS-1:0]    hit_mask;
    logic [MXPADS-1:0]    rest;
    logic                 load;
    logic                 at_limit;

    first_set_encoder #(
        .MXPADS    (MXPADS),
        .MXADRBITS (MXADRBITS)
    ) u_enc (
        .vpf_i   (work_vpf_q),
        .found_o (hit),
        .adr_o   (hit_adr)
    );

    assign hit_mask = hit ? (MXPADS'(1) << hit_adr) : '0;
    assign rest     = work_vpf_q & ~hit_mask;
    assign load     = !out_valid_q || out_ready;
    assign at_limit = (ctr_q == IDX_LAST);

    always_comb begin
        state_d     = state_q;
        work_vpf_d  = work_vpf_q;
        work_cnt_d  = work_cnt_q;
        ctr_d       = ctr_q;
        out_valid_d = out_valid_q;
        out_found_d = out_found_q;
        adr_d       = adr_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        out_last_d  = out_last_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_vpf_d = vpfs_in;
                    work_cnt_d = cnts_in;
                    ctr_d      = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (load) begin
                    out_valid_d = 1'b1;
                    out_found_d = hit;
                    idx_d       = ctr_q;
                    if (hit) begin
                        adr_d      = hit_adr;
                        cnt_d      = work_cnt_q[hit_adr*MXCNTBITS +: MXCNTBITS];
                        work_vpf_d = rest;
                        ctr_d      = ctr_q + MXIDXBITS'(1);
                        out_last_d = ~|rest | at_limit;
                        overflow_d = |rest & at_limit;
                    end else begin
                        // Only reachable on the first load: an empty frame yields one null beat.
                        adr_d      = ADR_NONE;
                        cnt_d      = '0;
                        out_last_d = 1'b1;
                        overflow_d = 1'b0;
                    end
                    if (out_last_d) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_found_d = 1'b0;
                    out_last_d  = 1'b0;
                    overflow_d  = 1'b0;
                    adr_d       = ADR_NONE;
                    cnt_d       = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            work_vpf_q  <= '0;
            work_cnt_q  <= '0;
            ctr_q       <= '0;
            out_valid_q <= 1'b0;
            out_found_q <= 1'b0;
            adr_q       <= ADR_NONE;
            cnt_q       <= '0;
            idx_q       <= '0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_vpf_q  <= work_vpf_d;
            work_cnt_q  <= work_cnt_d;
            ctr_q       <= ctr_d;
            out_valid_q <= out_valid_d;
            out_found_q <= out_found_d;
            adr_q       <= adr_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign out_found = out_found_q;
    assign adr       = adr_q;
    assign cnt       = cnt_q;
    assign idx       = idx_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cluster_extractor.sv
// Bench for cluster_extractor: directed vector table, mid-frame reset sequence and random
// frames checked against a pad-order reference model.
module tb_cluster_extractor;
    import cluster_pkg::*;

    localparam int NP = 768;
    localparam int CB = 3;
    localparam int AB = 11;
    localparam int NC = 8;
    localparam int IB = 4;
    localparam int NV = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [NP-1:0]     vpfs_in;
    logic [NP*CB-1:0]  cnts_in;
    logic              out_valid;
    logic              out_ready;
    logic              out_found;
    logic [AB-1:0]     adr;
    logic [CB-1:0]     cnt;
    logic [IB-1:0]     idx;
    logic              out_last;
    logic              overflow;

    always #5 clock = ~clock;

    cluster_extractor #(
        .MXPADS     (NP),
        .MXCNTBITS  (CB),
        .MXADRBITS  (AB),
        .MXCLUSTERS (NC),
        .MXIDXBITS  (IB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vpfs_in   (vpfs_in),
        .cnts_in   (cnts_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_found (out_found),
        .adr       (adr),
        .cnt       (cnt),
        .idx       (idx),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    typedef struct packed {
        logic [1:0]        mode;
        logic [3:0]        np;
        logic [11:0][9:0]  pad;
        logic [11:0][2:0]  cv;
        logic [3:0]        nb;
        logic [7:0][10:0]  eadr;
        logic [7:0][2:0]   ecnt;
        logic              eovf;
    } vec_t;

    vec_t vecs [NV];

    int tests = 0;
    int fails = 0;

    int          exp_adr [$];
    int          exp_cnt [$];
    bit          exp_ovf;
    logic [31:0] got_found [$];
    logic [31:0] got_adr [$];
    logic [31:0] got_cnt [$];
    logic [31:0] got_idx [$];
    logic [31:0] got_last [$];
    logic [31:0] got_ovf [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":in_ready"}, 32'(in_ready), 32'(1));
        check({tag, ":out_valid"}, 32'(out_valid), 32'(0));
        check({tag, ":out_found"}, 32'(out_found), 32'(0));
        check({tag, ":adr"}, 32'(adr), 32'(ADR_INVALID));
        check({tag, ":cnt"}, 32'(cnt), 32'(0));
        check({tag, ":idx"}, 32'(idx), 32'(0));
        check({tag, ":last"}, 32'(out_last), 32'(0));
        check({tag, ":overflow"}, 32'(overflow), 32'(0));
    endtask

    // Reference: clusters are the set pads in ascending order, truncated to NC.
    task automatic model(input logic [NP-1:0] v, input logic [NP*CB-1:0] c);
        int total;
        total = 0;
        exp_adr.delete();
        exp_cnt.delete();
        for (int p = 0; p < NP; p++) begin
            if (v[p]) begin
                total++;
                if (exp_adr.size() < NC) begin
                    exp_adr.push_back(p);
                    exp_cnt.push_back(int'(c[p*CB +: CB]));
                end
            end
        end
        exp_ovf = (total > NC);
        if (total == 0) begin
            exp_adr.push_back(2047);
            exp_cnt.push_back(0);
        end
    endtask

    // mode 0: out_ready held high; 1: out_ready pattern 1,0,0; 2: random out_ready.
    // Modes 1 and 2 also throw in_valid pulses with junk data while the block is busy.
    task automatic run_frame(input logic [NP-1:0] v, input logic [NP*CB-1:0] c,
                             input int mode, input string tag);
        int                  guard;
        int                  cyc;
        int                  first;
        int                  n;
        bit                  done;
        bit                  stalled;
        logic [AB+CB+IB+3:0] snap;
        logic [AB+CB+IB+3:0] now_s;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check({tag, ":in_ready_before"}, 32'(in_ready), 32'(1));
        vpfs_in  = v;
        cnts_in  = c;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        got_found.delete(); got_adr.delete(); got_cnt.delete();
        got_idx.delete(); got_last.delete(); got_ovf.delete();
        cyc = 0; first = -1; done = 1'b0; stalled = 1'b0; snap = '0;
        while (!done && cyc < 300) begin
            now_s = {out_valid, out_found, adr, cnt, idx, out_last, overflow};
            if (stalled) check({tag, ":stall_hold"}, 32'(now_s), 32'(snap));
            if (out_valid && first < 0) first = cyc;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode != 0 && !in_ready) begin
                in_valid = 1'($urandom_range(0, 1));
                vpfs_in  = {24{$urandom()}};
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                got_found.push_back(32'(out_found));
                got_adr.push_back(32'(adr));
                got_cnt.push_back(32'(cnt));
                got_idx.push_back(32'(idx));
                got_last.push_back(32'(out_last));
                got_ovf.push_back(32'(overflow));
                if (out_last) done = 1'b1;
            end
            stalled = out_valid && !out_ready;
            snap    = now_s;
            @(negedge clock);
            cyc++;
        end
        in_valid = 1'b0;
        vpfs_in  = v;
        check({tag, ":frame_done"}, 32'(done), 32'(1));
        check({tag, ":first_beat_cycle"}, 32'(first), 32'(1));
        n = exp_adr.size();
        check({tag, ":beats"}, 32'(got_adr.size()), 32'(n));
        for (int k = 0; k < n && k < got_adr.size(); k++) begin
            string bt;
            bt = $sformatf("%s:b%0d", tag, k);
            check({bt, ":found"}, got_found[k], 32'(exp_adr[k] != 2047));
            check({bt, ":adr"}, got_adr[k], 32'(exp_adr[k]));
            check({bt, ":cnt"}, got_cnt[k], 32'(exp_cnt[k]));
            check({bt, ":idx"}, got_idx[k], 32'(k));
            check({bt, ":last"}, got_last[k], 32'(k == n - 1));
            check({bt, ":overflow"}, got_ovf[k], 32'((k == n - 1) && exp_ovf));
        end
        check({tag, ":in_ready_after"}, 32'(in_ready), 32'(1));
        check({tag, ":idle_valid"}, 32'(out_valid), 32'(0));
        check({tag, ":idle_adr"}, 32'(adr), 32'(ADR_INVALID));
        check({tag, ":idle_last"}, 32'(out_last), 32'(0));
    endtask

    initial begin
        logic [NP-1:0]    v;
        logic [NP*CB-1:0] c;
        int               k;

        // Directed table: pads/counts in, expected beat addresses/counts out.
        for (int i = 0; i < NV; i++) vecs[i] = '0;
        // Single cluster
        vecs[0].np = 4'd1; vecs[0].pad[0] = 10'd37; vecs[0].cv[0] = 3'd5;
        vecs[0].nb = 4'd1; vecs[0].eadr[0] = 11'd37; vecs[0].ecnt[0] = 3'd5;
        // Ordering
        vecs[1].np = 4'd3;
        vecs[1].pad[0] = 10'd700; vecs[1].pad[1] = 10'd3; vecs[1].pad[2] = 10'd511;
        vecs[1].cv[0] = 3'd1; vecs[1].cv[1] = 3'd2; vecs[1].cv[2] = 3'd7;
        vecs[1].nb = 4'd3;
        vecs[1].eadr[0] = 11'd3; vecs[1].eadr[1] = 11'd511; vecs[1].eadr[2] = 11'd700;
        vecs[1].ecnt[0] = 3'd2; vecs[1].ecnt[1] = 3'd7; vecs[1].ecnt[2] = 3'd1;
        // Overflow: ten pads, eight extracted
        vecs[2].np = 4'd10; vecs[2].nb = 4'd8; vecs[2].eovf = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vecs[2].pad[i] = 10'(i); vecs[2].cv[i] = 3'(i);
        end
        for (int i = 0; i < 8; i++) begin
            vecs[2].eadr[i] = 11'(i); vecs[2].ecnt[i] = 3'(i);
        end
        // Empty frame
        vecs[3].nb = 4'd1; vecs[3].eadr[0] = 11'h7ff; vecs[3].ecnt[0] = 3'd0;
        // Backpressure 1,0,0 with ignored in_valid pulses
        vecs[4].mode = 2'd1; vecs[4].np = 4'd3; vecs[4].nb = 4'd3;
        vecs[4].pad[0] = 10'd767; vecs[4].pad[1] = 10'd5; vecs[4].pad[2] = 10'd64;
        vecs[4].cv[0] = 3'd6; vecs[4].cv[1] = 3'd3; vecs[4].cv[2] = 3'd4;
        vecs[4].eadr[0] = 11'd5; vecs[4].eadr[1] = 11'd64; vecs[4].eadr[2] = 11'd767;
        vecs[4].ecnt[0] = 3'd3; vecs[4].ecnt[1] = 3'd4; vecs[4].ecnt[2] = 3'd6;
        // Exactly MXCLUSTERS pads at the top edge: last without overflow
        vecs[5].np = 4'd8; vecs[5].nb = 4'd8;
        for (int i = 0; i < 8; i++) begin
            vecs[5].pad[i] = 10'(760 + i); vecs[5].cv[i] = 3'(7 - i);
            vecs[5].eadr[i] = 11'(760 + i); vecs[5].ecnt[i] = 3'(7 - i);
        end
        // Pad 0 alone
        vecs[6].np = 4'd1; vecs[6].pad[0] = 10'd0; vecs[6].cv[0] = 3'd7;
        vecs[6].nb = 4'd1; vecs[6].eadr[0] = 11'd0; vecs[6].ecnt[0] = 3'd7;
        // Nine spread pads with random backpressure
        vecs[7].mode = 2'd2; vecs[7].np = 4'd9; vecs[7].nb = 4'd8; vecs[7].eovf = 1'b1;
        for (int i = 0; i < 9; i++) begin
            vecs[7].pad[i] = 10'(100 + 50 * i); vecs[7].cv[i] = 3'(i + 1);
        end
        for (int i = 0; i < 8; i++) begin
            vecs[7].eadr[i] = 11'(100 + 50 * i); vecs[7].ecnt[i] = 3'(i + 1);
        end

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; vpfs_in = '0; cnts_in = '0;
        @(negedge clock);
        check_reset_values("reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < NV; i++) begin
            v = '0;
            c = '0;
            for (int j = 0; j < int'(vecs[i].np); j++) begin
                v[vecs[i].pad[j]] = 1'b1;
                c[vecs[i].pad[j]*CB +: CB] = vecs[i].cv[j];
            end
            exp_adr.delete();
            exp_cnt.delete();
            for (int j = 0; j < int'(vecs[i].nb); j++) begin
                exp_adr.push_back(int'(vecs[i].eadr[j]));
                exp_cnt.push_back(int'(vecs[i].ecnt[j]));
            end
            exp_ovf = vecs[i].eovf;
            run_frame(v, c, int'(vecs[i].mode), $sformatf("vec%0d", i));
        end

        // Reset in the middle of a five-cluster frame
        v = '0;
        c = '0;
        for (int j = 1; j <= 5; j++) begin
            v[10*j] = 1'b1;
            c[10*j*CB +: CB] = 3'(j);
        end
        vpfs_in = v; cnts_in = c; out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("midrst:beat1_adr", 32'(adr), 32'(20));
        @(negedge clock);
        #2 reset = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge clock);
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            check("midrst:no_beat", 32'(out_valid), 32'(0));
        end
        v = '0;
        c = '0;
        v[100] = 1'b1;
        c[100*CB +: CB] = 3'd6;
        model(v, c);
        run_frame(v, c, 0, "after_rst");

        // Random frames against the reference model
        for (int f = 0; f < 40; f++) begin
            v = '0;
            c = {72{$urandom()}};
            k = $urandom_range(0, 12);
            if (k == 12) k = 30;
            for (int j = 0; j < k; j++) v[$urandom_range(0, NP - 1)] = 1'b1;
            model(v, c);
            run_frame(v, c, $urandom_range(0, 2), $sformatf("rnd%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
